// File: rtl/alu4_result_stage.sv
// alu4_result_stage
// Registered execute/result stage of the small arithmetic unit. It accepts
// two operands and an opcode through a valid/ready handshake. Single-cycle
// ops (ADD, SUB, AND, OR, XOR, XNOR, PASS A) produce a result one cycle after
// accept. MUL runs as a MUL_CYCLES-step shift-add. The result and flags are
// held until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand/opcode presented
//   in_ready   stage can accept an operand/opcode (combinational)
//   a, b       WIDTH-bit operands
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR,
//              110 MUL, 111 PASS A
//   out_valid  result registered and held
//   out_ready  consumer accepts the result
//   result     2*WIDTH bits; upper half is only non-zero for MUL
//   carry      ADD carry-out / SUB no-borrow, 0 otherwise
//   zero       result == 0 over the full 2*WIDTH width
//   overflow   signed overflow for ADD/SUB, 0 otherwise
module alu4_result_stage #(
    parameter int WIDTH      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic                 overflow
);

    localparam int CW = $clog2(MUL_CYCLES) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    logic                 accept;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic [2*WIDTH-1:0]   alu_wide;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 mul_last;

    // A new op can enter when idle, or when the held result retires in the
    // same edge, which gives one result per cycle for single-cycle ops.
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Single-cycle datapath. SUB is A + ~B + 1 so its carry-out is the
    // no-borrow flag. Overflow uses the sign rule on the WIDTH-bit result.
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_XNOR: alu_res = ~(a ^ b);
            OP_PASS: alu_res = a;
            default: alu_res = '0;
        endcase
        alu_wide = {{WIDTH{1'b0}}, alu_res};
    end

    // One shift-add step. The multiplier is shifted right and the
    // multiplicand left each step, so bit 0 of the multiplier register is
    // always multiplier bit[count] and the multiplicand is already shifted
    // by count.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        mul_last = (count == CW'(MUL_CYCLES - 1));
    end

    // Control and result registers. Reset aborts any running MUL or held
    // result in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                count  <= '0;
                state  <= MUL_RUN;
            end else begin
                result   <= alu_wide;
                carry    <= alu_carry;
                zero     <= (alu_wide == '0);
                overflow <= alu_ovf;
                state    <= HOLD;
            end
        end else if (state == MUL_RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (mul_last) begin
                result   <= acc_next;
                zero     <= (acc_next == '0);
                carry    <= 1'b0;
                overflow <= 1'b0;
                state    <= HOLD;
            end
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end else if ((state != IDLE) && (state != HOLD)) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu4_result_stage.sv
// tb_alu4_result_stage
// Directed bench for alu4_result_stage. A behavioural model computes each
// expected result from plain integer arithmetic and queues it at accept; a
// compare process checks every held result against the queue head. Directed
// checks with hand-computed literals pin timing and the model itself.
module tb_alu4_result_stage;

    localparam int WIDTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   a;
    logic [3:0]   b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   result;
    logic         carry;
    logic         zero;
    logic         overflow;

    typedef struct {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       overflow;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   retired      = 0;
    int   stall_cycles = 0;

    always #5 clk = ~clk;

    alu4_result_stage #(.WIDTH(WIDTH), .MUL_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow)
    );

    // Expected outputs from integer arithmetic on the opcode's meaning.
    function automatic exp_t model(input int opc, input int av, input int bv);
        exp_t e;
        int   sa;
        int   sb;
        int   sr;
        int   r;
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        r  = 0;
        e.carry    = 1'b0;
        e.overflow = 1'b0;
        case (opc)
            0: begin
                r = av + bv;
                e.carry = (r > 15);
                sr = sa + sb;
                e.overflow = (sr > 7) || (sr < -8);
                r = r % 16;
            end
            1: begin
                r = av - bv;
                e.carry = (av >= bv);
                sr = sa - sb;
                e.overflow = (sr > 7) || (sr < -8);
                r = (r + 16) % 16;
            end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = (~(av ^ bv)) & 15;
            6: r = av * bv;
            default: r = av;
        endcase
        e.result = 8'(r);
        e.zero   = (r == 0);
        return e;
    endfunction

    task automatic check_val(input string name, input int act, input int want);
        tests_run++;
        if (act !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Every cycle a result is held it must equal the oldest outstanding
    // expectation; it retires when the consumer is ready.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected out_valid: got 1 want 0 (no op outstanding)");
            end else begin
                check_val("model result",   int'(result),   int'(exp_q[0].result));
                check_val("model carry",    int'(carry),    int'(exp_q[0].carry));
                check_val("model zero",     int'(zero),     int'(exp_q[0].zero));
                check_val("model overflow", int'(overflow), int'(exp_q[0].overflow));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    retired++;
                end
            end
        end
    end

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for in_ready, record the expectation
    // and release in_valid just after the accepting edge.
    task automatic applyStimulus(input int opc, input int av, input int bv);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        op       = 3'(opc);
        a        = 4'(av);
        b        = 4'(bv);
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept timeout: got in_ready=%0b want 1", in_ready);
        end else begin
            exp_q.push_back(model(opc, av, bv));
        end
        stall_cycles += waited;
        to_edge();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int v, input int rdy,
                               input int res, input int c, input int z, input int o);
        check_val({name, " out_valid"}, int'(out_valid), v);
        check_val({name, " in_ready"},  int'(in_ready),  rdy);
        check_val({name, " result"},    int'(result),    res);
        check_val({name, " carry"},     int'(carry),     c);
        check_val({name, " zero"},      int'(zero),      z);
        check_val({name, " overflow"},  int'(overflow),  o);
    endtask

    initial begin
        #500000;
        tests_failed++;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   r0;
        int   vec_op [8] = '{0, 1, 2, 3, 4, 5, 7, 0};
        int   vec_a  [8] = '{1, 5, 15, 8, 15, 0, 11, 15};
        int   vec_b  [8] = '{2, 3, 3, 1, 15, 0, 0, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;

        // Pin the model with hand-computed values.
        e = model(0, 9, 7);
        check_val("pin add 9+7 result", int'(e.result), 'h00);
        check_val("pin add 9+7 carry",  int'(e.carry),  1);
        check_val("pin add 9+7 zero",   int'(e.zero),   1);
        e = model(0, 7, 1);
        check_val("pin add 7+1 overflow", int'(e.overflow), 1);
        e = model(1, 3, 5);
        check_val("pin sub 3-5 result", int'(e.result), 'h0E);
        check_val("pin sub 3-5 carry",  int'(e.carry),  0);
        e = model(6, 15, 15);
        check_val("pin mul f*f result", int'(e.result), 'hE1);
        e = model(5, 10, 6);
        check_val("pin xnor a,6 result", int'(e.result), 'h03);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset idle", 0, 1, 'h00, 0, 0, 0);
        to_edge();

        applyStimulus(4, 'hA, 'h6);
        @(negedge clk);
        checkOutput("xor a^6", 1, 1, 'h0C, 0, 0, 0);
        to_edge();

        applyStimulus(0, 'h9, 'h7);
        @(negedge clk);
        checkOutput("add 9+7", 1, 1, 'h00, 1, 1, 0);
        to_edge();

        applyStimulus(0, 'h7, 'h1);
        @(negedge clk);
        checkOutput("add 7+1", 1, 1, 'h08, 0, 0, 1);
        to_edge();

        applyStimulus(1, 'h3, 'h5);
        @(negedge clk);
        checkOutput("sub 3-5", 1, 1, 'h0E, 0, 0, 0);
        to_edge();

        // MUL: busy for four cycles, result visible in the fifth.
        applyStimulus(6, 'hF, 'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("mul busy in_ready",  int'(in_ready),  0);
            check_val("mul busy out_valid", int'(out_valid), 0);
        end
        @(negedge clk);
        checkOutput("mul f*f", 1, 1, 'hE1, 0, 0, 0);
        to_edge();

        applyStimulus(6, 'h0, 'h9);
        repeat (4) @(negedge clk);
        @(negedge clk);
        checkOutput("mul 0*9", 1, 1, 'h00, 0, 1, 0);
        to_edge();

        // Backpressure: held result must not move while junk is offered.
        out_ready = 1'b0;
        applyStimulus(0, 'h2, 'h3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op       = 3'(i + 1);
            a        = 4'(i * 5 + 1);
            b        = 4'(15 - i);
            @(negedge clk);
            checkOutput("hold add", 1, 0, 'h05, 0, 0, 0);
            to_edge();
        end
        out_ready = 1'b1;
        applyStimulus(2, 'hC, 'hA);
        @(negedge clk);
        checkOutput("and after hold", 1, 1, 'h08, 0, 0, 0);
        to_edge();

        // Reset in the middle of a MUL aborts it with no output pulse.
        applyStimulus(6, 'h3, 'h3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("reset mid mul", 0, 1, 'h00, 0, 0, 0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_val("no pulse after abort", int'(out_valid), 0);
        end
        to_edge();

        // Back-to-back single-cycle stream.
        stall_cycles = 0;
        r0 = retired;
        for (int i = 0; i < 8; i++) applyStimulus(vec_op[i], vec_a[i], vec_b[i]);
        @(negedge clk);
        to_edge();
        @(negedge clk);
        check_val("stream retired", retired - r0, 8);
        check_val("stream stalls", stall_cycles, 0);
        to_edge();

        // XOR/XNOR sweep over every operand pair.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                applyStimulus(4, x, y);
                applyStimulus(5, x, y);
            end
        end
        to_edge();
        to_edge();
        @(negedge clk);
        check_val("sweep drained", exp_q.size(), 0);
        check_val("final out_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
